nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
Multi-word adder that sequences WIDTH-bit operands one 4-bit slice per clock through a ripple-carry nibble adder. A registered carry links the slices.
- Sits directly upstream of the 4-bit adder datapath and feeds it operand nibbles and carry-in.
- Collects the nibble sums into a full-width result.
- Trades latency for area, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
NSLICE, WIDTH/4, derived localparam; number of nibble cycles per operation

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operands this cycle
a  input  WIDTH  operand A (unsigned or two's complement)
b  input  WIDTH  operand B
cy_in  input  1  initial carry into bit 0
out_valid  output  1  result valid, held until accepted
out_ready  input  1  downstream accepts result
s  output  WIDTH  sum a+b+cy_in, modulo 2^WIDTH
cy_out  output  1  carry out of bit WIDTH-1
ovf  output  1  signed overflow: carry into MSB xor carry out of MSB
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync-safe deassert at clk edge):
  - State goes to IDLE.
  - out_valid=0, s=0, cy_out=0, ovf=0, busy=0, in_ready=1.
  - Internal operand/result shift registers, slice counter and carry register are cleared.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a, b into shift registers, load carry register with cy_in, clear counter, go to RUN.
- RUN (exactly NSLICE cycles):
  - Each cycle, the nibble adder adds the low nibbles of the A/B shift registers plus the carry register.
  - Sum nibble shifts into the result register from the top.
  - A/B shift right by 4; carry register takes the nibble carry-out.
  - On the last slice, also capture the carry into bit WIDTH-1 for ovf.
  - Counter at NSLICE-1 -> go to DONE.
  - in_ready=0. in_valid is ignored and the operands are not sampled.
- DONE:
  - out_valid=1; s, cy_out, ovf stable until handshake.
  - out_ready=0: hold indefinitely.
  - out_ready=1 and in_valid=0: go to IDLE, out_valid drops next cycle.
  - out_ready=1 and in_valid=1: accept the new operands in the same cycle and go straight to RUN.
  - in_ready = out_ready in DONE, combinational from out_ready only.
- Latency: operands accepted at edge N -> out_valid high after edge N+NSLICE. Max throughput is one result per NSLICE+1 cycles.
- Outputs after the handshake:
  - s/cy_out/ovf keep their last value until the next DONE entry.
  - They are overwritten only at the RUN->DONE edge.
  - Consumers must qualify them with out_valid.
- Arithmetic: full WIDTH+1-bit result is {cy_out, s} = a + b + cy_in. There is no saturation.
- Reset mid-RUN or mid-DONE: the operation is discarded with no partial output. out_valid never glitches high.
- in_valid with X operands while in RUN must not corrupt state.

Decomposition:
- Shared package adder_pkg holds:
  - SLICE_W = 4
  - state enum type (IDLE, RUN, DONE)
  - a function computing NSLICE from WIDTH
- One natural combinational sub-module, nibble_add: 4-bit a, b, carry-in; 4-bit sum, carry-out, and carry into bit 3 (needed for ovf).
- The FSM, counter and shift registers live in nibble_serial_adder.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cy_in=0 -> after 4 RUN cycles: out_valid=1, s=0x5555, cy_out=0, ovf=0.
- a=0xFFFF, b=0x0001, cy_in=0 -> s=0x0000, cy_out=1, ovf=0. Carry must ripple through all 4 slices via the carry register.
- a=0x7FFF, b=0x0000, cy_in=1 -> s=0x8000, cy_out=0, ovf=1. Also a=0x8000, b=0x8000 -> s=0x0000, cy_out=1, ovf=1.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, s, cy_out stay stable, in_ready=0. Then out_ready=1 with in_valid=1 (0x0001+0x0001) -> new op accepted the same cycle, next result s=0x0002.
- Reset mid-RUN: assert rst asynchronously after 2 slices of 0xAAAA+0x5555 -> out_valid=0, s=0, in_ready=1 immediately. A subsequent 0x0003+0x0004 yields 0x0007.
- Random regression: 1000 operand triples with random out_ready stalls and in_valid during RUN -> compare {cy_out, s, ovf} against a behavioural a+b+cy_in model. Every accepted op produces exactly one result.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM state
// type and the slice-count helper used to size the sequencing counter.
package adder_pkg;

  localparam int SLICE_W = 4;

  // One-hot-free binary encoding; DONE is chosen so that no single-step
  // transition out of IDLE or RUN passes through the DONE code.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Number of nibble cycles needed to cover a WIDTH-bit operand.
  function automatic int calc_nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high. The producer holds valid and its payload stable until that edge;
// ready may depend combinationally on the other side's ready, never on valid.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cy_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cy_out;
  logic             ovf;
  logic             busy;

  // Operand source / result sink side.
  modport master (
    output in_valid, a, b, cy_in, out_ready,
    input  in_ready, out_valid, s, cy_out, ovf, busy
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cy_in, out_ready,
    output in_ready, out_valid, s, cy_out, ovf, busy
  );
endinterface

// File: rtl/nibble_serial_adder_nibble_add.sv
// 4-bit ripple-carry adder slice. Also reports the carry into its top bit so
// the caller can derive signed overflow on the most significant slice.
module nibble_add
  import adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c_msb
);

  logic [SLICE_W:0] c;

  // Bit-serial ripple through the four bit positions.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[SLICE_W];
  assign c_msb = c[SLICE_W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that feeds WIDTH-bit operands through one nibble adder,
// low slice first, linking slices with a registered carry. The result is
// assembled in a shift register and published only when the last slice
// completes, so s/cy_out/ovf never show a partial sum.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus,
  output state_t                dbg_state
);

  localparam int NSLICE = calc_nslice(WIDTH);
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  generate
    if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] s_q;
  logic             cy_q, ovf_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last_slice;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             busy_c;

  logic [SLICE_W-1:0] nib_sum;
  logic               nib_cout;
  logic               nib_cmsb;

  logic [WIDTH+SLICE_W-1:0] res_cat;
  logic [WIDTH-1:0]         res_next;

  nibble_add u_nibble_add (
    .a     (a_sr[SLICE_W-1:0]),
    .b     (b_sr[SLICE_W-1:0]),
    .cin   (carry),
    .sum   (nib_sum),
    .cout  (nib_cout),
    .c_msb (nib_cmsb)
  );

  // New nibble enters at the top; after NSLICE shifts the low slice sits at
  // the bottom. Concatenating first keeps this legal when WIDTH == 4.
  assign res_cat  = {nib_sum, res_sr};
  assign res_next = res_cat[WIDTH+SLICE_W-1:SLICE_W];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    accept      = 1'b0;
    last_slice  = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy_c = 1'b1;
        if (cnt == LAST_CNT) begin
          last_slice = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        // Result slot frees on this edge, so a waiting operand can chain in.
        in_ready_c  = bus.out_ready;
        if (bus.out_ready) begin
          accept     = bus.in_valid;
          state_next = bus.in_valid ? RUN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand/result shift registers, slice counter, carry and published result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s_q    <= '0;
      cy_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      carry  <= bus.cy_in;
      res_sr <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> SLICE_W;
      b_sr   <= b_sr >> SLICE_W;
      carry  <= nib_cout;
      res_sr <= res_next;
      cnt    <= cnt + 1'b1;
      if (last_slice) begin
        s_q   <= res_next;
        cy_q  <= nib_cout;
        ovf_q <= nib_cout ^ nib_cmsb;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.s         = s_q;
  assign bus.cy_out    = cy_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state;

endmodule
